// File: rtl/enemy.sv
// Wandering enemy sprite: steps one pixel per move period, turns clockwise when
// blocked, blinks while dying after being caught in an explosion, then vanishes.
module enemy #(
    parameter logic [9:0]  START_X      = 10'd208,
    parameter logic [9:0]  START_Y      = 10'd99,
    parameter logic [9:0]  X_MIN        = 10'd176,
    parameter logic [9:0]  X_MAX        = 10'd720,
    parameter logic [9:0]  Y_MIN        = 10'd67,
    parameter logic [9:0]  Y_MAX        = 10'd451,
    parameter logic [23:0] MOVE_DIV     = 24'd1_000_000,
    parameter logic [26:0] DEATH_CYCLES = 27'd100_000_000,
    parameter int          BLINK_BIT    = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  v_x,
    input  logic [9:0]  v_y,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic [3:0]  enemy_blocked,
    input  logic        explosion_on,
    output logic [9:0]  e_x,
    output logic [9:0]  e_y,
    output logic        enemy_on,
    output logic [11:0] rgb_out,
    output logic        enemy_alive,
    output logic        hit_bomberman
);

    typedef enum logic [1:0] {ALIVE, DYING, DEAD} state_t;
    typedef enum logic [1:0] {DIR_R, DIR_D, DIR_L, DIR_U} dir_t;

    state_t      state_reg;
    dir_t        dir_reg;
    logic [9:0]  x_reg;
    logic [9:0]  y_reg;
    logic [23:0] tick_reg;
    logic [26:0] death_reg;
    logic        hit_reg;

    logic        tick;
    logic        kill;
    logic        visible;
    logic        in_x;
    logic        in_y;
    logic        cur_blocked;
    logic        hit_next;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [3:0]  wall_by_dir;
    logic [3:0]  edge_by_dir;
    logic [3:0]  blocked_by_dir;

    // Both vectors indexed by dir_t; enemy_blocked arrives ordered {L,R,U,D}.
    assign wall_by_dir = {enemy_blocked[1], enemy_blocked[3], enemy_blocked[0], enemy_blocked[2]};
    assign edge_by_dir = {(y_reg <= Y_MIN), (x_reg <= X_MIN), (y_reg >= Y_MAX), (x_reg >= X_MAX)};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_blocked
            assign blocked_by_dir[gi] = wall_by_dir[gi] | edge_by_dir[gi];
        end
    endgenerate

    always_comb begin
        cur_blocked = blocked_by_dir[dir_reg];
        tick        = (tick_reg == MOVE_DIV - 24'd1);
        // Widen before adding 32 so sprites near 1023 do not wrap.
        in_x        = ({1'b0, v_x} >= {1'b0, x_reg}) && ({1'b0, v_x} < ({1'b0, x_reg} + 11'd32));
        in_y        = ({1'b0, v_y} >= {1'b0, y_reg}) && ({1'b0, v_y} < ({1'b0, y_reg} + 11'd32));
        visible     = (state_reg == ALIVE) || ((state_reg == DYING) && !death_reg[BLINK_BIT]);
        enemy_on    = in_x && in_y && visible;
        kill        = (state_reg == ALIVE) && explosion_on && enemy_on;
        dx          = (b_x >= x_reg) ? (b_x - x_reg) : (x_reg - b_x);
        dy          = (b_y >= y_reg) ? (b_y - y_reg) : (y_reg - b_y);
        // Gating with kill keeps the cycle after a kill free of a stale hit.
        hit_next    = (state_reg == ALIVE) && !kill && (dx < 10'd32) && (dy < 10'd32);
    end

    always_comb begin
        rgb_out = 12'h000;
        case (state_reg)
            ALIVE:   rgb_out = 12'hF0F;
            DYING:   rgb_out = 12'hFFF;
            default: rgb_out = 12'h000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ALIVE;
            dir_reg   <= DIR_R;
            x_reg     <= START_X;
            y_reg     <= START_Y;
            tick_reg  <= '0;
            death_reg <= '0;
            hit_reg   <= 1'b0;
        end else begin
            hit_reg <= hit_next;
            case (state_reg)
                ALIVE: begin
                    if (kill) begin
                        state_reg <= DYING;
                        death_reg <= '0;
                    end else begin
                        tick_reg <= tick ? 24'd0 : tick_reg + 24'd1;
                        if (tick) begin
                            if (cur_blocked) begin
                                case (dir_reg)
                                    DIR_R:   dir_reg <= DIR_D;
                                    DIR_D:   dir_reg <= DIR_L;
                                    DIR_L:   dir_reg <= DIR_U;
                                    default: dir_reg <= DIR_R;
                                endcase
                            end else begin
                                case (dir_reg)
                                    DIR_R:   x_reg <= x_reg + 10'd1;
                                    DIR_D:   y_reg <= y_reg + 10'd1;
                                    DIR_L:   x_reg <= x_reg - 10'd1;
                                    default: y_reg <= y_reg - 10'd1;
                                endcase
                            end
                        end
                    end
                end
                DYING: begin
                    death_reg <= death_reg + 27'd1;
                    if (death_reg == DEATH_CYCLES - 27'd1)
                        state_reg <= DEAD;
                end
                default: ;
            endcase
        end
    end

    assign e_x           = x_reg;
    assign e_y           = y_reg;
    assign enemy_alive   = (state_reg == ALIVE);
    assign hit_bomberman = hit_reg;

endmodule

// File: tb/tb_enemy.sv
// Bench for enemy: a reference model queues expected register outputs each cycle,
// popped and compared after the edge; directed checks cover the key scenarios.
module tb_enemy;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  v_x, v_y, b_x, b_y;
    logic [3:0]  enemy_blocked;
    logic        explosion_on;
    logic [9:0]  e_x, e_y;
    logic        enemy_on;
    logic [11:0] rgb_out;
    logic        enemy_alive;
    logic        hit_bomberman;

    always #5 clk = ~clk;

    enemy #(
        .MOVE_DIV    (24'd4),
        .DEATH_CYCLES(27'd64),
        .BLINK_BIT   (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .v_x          (v_x),
        .v_y          (v_y),
        .b_x          (b_x),
        .b_y          (b_y),
        .enemy_blocked(enemy_blocked),
        .explosion_on (explosion_on),
        .e_x          (e_x),
        .e_y          (e_y),
        .enemy_on     (enemy_on),
        .rgb_out      (rgb_out),
        .enemy_alive  (enemy_alive),
        .hit_bomberman(hit_bomberman)
    );

    typedef struct {
        int x;
        int y;
        int alive;
        int hit;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: state 0=alive 1=dying 2=dead, dir 0=R 1=D 2=L 3=U
    int m_x = 208, m_y = 99, m_dir = 0, m_tick = 0, m_state = 0, m_dcnt = 0, m_hit = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int m_on();
        int vis;
        vis = (m_state == 0) || (m_state == 1 && ((m_dcnt >> 3) & 1) == 0);
        return (vis != 0 && int'(v_x) >= m_x && int'(v_x) < m_x + 32 &&
                int'(v_y) >= m_y && int'(v_y) < m_y + 32) ? 1 : 0;
    endfunction

    function automatic int m_blocked(input int d);
        case (d)
            0:       return (enemy_blocked[2] || m_x + 1 > 720) ? 1 : 0;
            1:       return (enemy_blocked[0] || m_y + 1 > 451) ? 1 : 0;
            2:       return (enemy_blocked[3] || m_x - 1 < 176) ? 1 : 0;
            default: return (enemy_blocked[1] || m_y - 1 < 67) ? 1 : 0;
        endcase
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // One clock: check combinational outputs, predict and queue, then compare after the edge.
    task automatic cycle();
        exp_t e, got;
        int nx, ny, ndir, nt, ns, nd, nh, on;
        #1;
        on = m_on();
        chk("enemy_on", enemy_on, on);
        if (on != 0)
            chk("rgb_out", rgb_out, (m_state == 0) ? 32'hF0F : 32'hFFF);
        nx = m_x; ny = m_y; ndir = m_dir; nt = m_tick; ns = m_state; nd = m_dcnt; nh = 0;
        if (reset) begin
            nx = 208; ny = 99; ndir = 0; nt = 0; ns = 0; nd = 0;
        end else if (m_state == 0) begin
            if (explosion_on && on != 0) begin
                ns = 1; nd = 0;
            end else begin
                nh = (absd(m_x, int'(b_x)) < 32 && absd(m_y, int'(b_y)) < 32) ? 1 : 0;
                nt = (m_tick == 3) ? 0 : m_tick + 1;
                if (m_tick == 3) begin
                    if (m_blocked(m_dir) != 0) ndir = (m_dir + 1) % 4;
                    else begin
                        case (m_dir)
                            0: nx = m_x + 1;
                            1: ny = m_y + 1;
                            2: nx = m_x - 1;
                            default: ny = m_y - 1;
                        endcase
                    end
                end
            end
        end else if (m_state == 1) begin
            nd = m_dcnt + 1;
            if (m_dcnt == 63) ns = 2;
        end
        e.x = nx; e.y = ny; e.alive = (ns == 0) ? 1 : 0; e.hit = nh;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("e_x", e_x, got.x);
        chk("e_y", e_y, got.y);
        chk("enemy_alive", enemy_alive, got.alive);
        chk("hit_bomberman", hit_bomberman, got.hit);
        m_x = nx; m_y = ny; m_dir = ndir; m_tick = nt; m_state = ns; m_dcnt = nd; m_hit = nh;
    endtask

    task automatic to_tick();
        while (m_tick != 3) cycle();
    endtask

    initial begin
        int y0, x0, vis_cnt, budget;
        reset = 1'b1; v_x = '0; v_y = '0; b_x = '0; b_y = '0;
        enemy_blocked = '0; explosion_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", e_x, 208);
        chk("reset_y", e_y, 99);
        chk("reset_alive", enemy_alive, 1);
        chk("reset_hit", hit_bomberman, 0);
        reset = 1'b0;

        // Free running: three steps right in 12 cycles.
        repeat (12) cycle();
        chk("run12_x", e_x, 211);
        chk("run12_y", e_y, 99);

        // Wall to the right at a tick: hold, then move down.
        to_tick();
        enemy_blocked = 4'b0100;
        cycle();
        chk("wall_r_hold_x", e_x, 211);
        enemy_blocked = 4'b0000;
        repeat (4) cycle();
        chk("turn_down_y", e_y, 100);
        chk("turn_down_x", e_x, 211);

        // Steer back to facing right: block D, then L, then U.
        to_tick(); enemy_blocked = 4'b0001; cycle();
        to_tick(); enemy_blocked = 4'b1000; cycle();
        to_tick(); enemy_blocked = 4'b0010; cycle();
        enemy_blocked = 4'b0000;

        // Walk to X_MAX; the next tick must rotate, not step out of range.
        budget = 0;
        while (e_x != 10'd720 && budget < 3000) begin
            cycle();
            budget++;
        end
        chk("reach_xmax", e_x, 720);
        y0 = int'(e_y);
        repeat (4) cycle();
        chk("xmax_hold_x", e_x, 720);
        chk("xmax_hold_y", e_y, y0);
        repeat (4) cycle();
        chk("xmax_down_y", e_y, y0 + 1);

        // Fully boxed: rotates every tick, never moves.
        enemy_blocked = 4'b1111;
        x0 = int'(e_x); y0 = int'(e_y);
        repeat (16) cycle();
        chk("boxed_x", e_x, x0);
        chk("boxed_y", e_y, y0);

        // Bomberman overlap boundary.
        b_x = e_x + 10'd31; b_y = e_y;
        cycle();
        chk("hit_edge31", hit_bomberman, 1);
        b_x = e_x + 10'd32;
        cycle();
        chk("hit_edge32", hit_bomberman, 0);
        b_x = e_x - 10'd31;
        cycle();
        chk("hit_left31", hit_bomberman, 1);

        // Kill on a tick cycle with the bomberman overlapping.
        b_x = e_x; b_y = e_y;
        v_x = e_x + 10'd5; v_y = e_y + 10'd5;
        enemy_blocked = 4'b0000;
        to_tick();
        x0 = int'(e_x); y0 = int'(e_y);
        explosion_on = 1'b1;
        cycle();
        chk("kill_alive", enemy_alive, 0);
        chk("kill_hit", hit_bomberman, 0);
        chk("kill_x", e_x, x0);
        chk("kill_y", e_y, y0);
        vis_cnt = (enemy_on === 1'b1) ? 1 : 0;
        repeat (63) begin
            cycle();
            if (enemy_on === 1'b1) vis_cnt++;
        end
        chk("dying_visible_cycles", vis_cnt, 32);
        repeat (6) cycle();
        chk("dead_enemy_on", enemy_on, 0);
        chk("dead_alive", enemy_alive, 0);
        chk("dead_hit", hit_bomberman, 0);
        chk("dead_x", e_x, x0);

        // Reset from DEAD, kill again, then reset mid-death.
        explosion_on = 1'b0;
        reset = 1'b1; cycle(); reset = 1'b0;
        v_x = e_x + 10'd5; v_y = e_y + 10'd5;
        explosion_on = 1'b1; cycle(); explosion_on = 1'b0;
        repeat (20) cycle();
        chk("mid_death_alive", enemy_alive, 0);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rst_dying_x", e_x, 208);
        chk("rst_dying_y", e_y, 99);
        chk("rst_dying_alive", enemy_alive, 1);
        v_x = 10'd210; v_y = 10'd101;
        #1;
        chk("rst_dying_on", enemy_on, 1);
        repeat (8) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
